// File: rtl/rdma_qp_pkg.sv
// Shared types for the RDMA QP connection scheduler: QP state encodings,
// response codes, request ops and the scheduler FSM state set.
package rdma_qp_pkg;

  typedef enum logic [2:0] {
    QP_RESET = 3'b000,
    QP_INIT  = 3'b001,
    QP_RTR   = 3'b010,
    QP_RTS   = 3'b011,
    QP_ERROR = 3'b111
  } qp_state_e;

  typedef enum logic [1:0] {
    RSP_OK        = 2'b00,
    RSP_TIMEOUT   = 2'b01,
    RSP_QP_ERR    = 2'b10,
    RSP_BAD_STATE = 2'b11
  } rsp_code_e;

  typedef enum logic {
    OP_CONNECT    = 1'b0,
    OP_DISCONNECT = 1'b1
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_CFG, S_W_INIT, S_CON1, S_W_RTR, S_CON2,
    S_W_RTS, S_DISC, S_W_RST, S_ABORT, S_W_ABORT, S_RESP
  } sched_state_e;

  // States that wait on qp_state and run the timeout counter.
  function automatic logic is_wait_state(input sched_state_e s);
    return (s == S_W_INIT) || (s == S_W_RTR) || (s == S_W_RTS) ||
           (s == S_W_RST)  || (s == S_W_ABORT);
  endfunction

endpackage

// File: rtl/rdma_qp_conn_sched_if.sv
// Requester-side bundle of the connection scheduler.
// Handshake: a requester raises req_valid[i] with req_op[i] and its QPN slice
// stable and holds them until it sees req_ready[i] high for one cycle; that
// cycle is the accept. Dropping req_valid before accept withdraws the request.
// rsp_valid[i] is a one-cycle pulse to the owner with rsp_code valid alongside;
// there is no backpressure on responses.
interface rdma_qp_conn_sched_if #(
  parameter int NUM_REQ   = 4,
  parameter int QPN_WIDTH = 16
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_op;
  logic [NUM_REQ*QPN_WIDTH-1:0] req_remote_qpn;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [1:0]                   rsp_code;
  logic                         busy;

  modport master (
    output req_valid, req_op, req_remote_qpn,
    input  req_ready, rsp_valid, rsp_code, busy
  );

  modport slave (
    input  req_valid, req_op, req_remote_qpn,
    output req_ready, rsp_valid, rsp_code, busy
  );
endinterface

// File: rtl/rdma_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer,
// wrapping; the pointer moves past the winner whenever a grant is issued.
module rdma_rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d;

  // Scan from the pointer and take the first active request.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en && !gnt_any && req[(int'(ptr_q) + k) % N]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'((int'(ptr_q) + k) % N);
        gnt[(int'(ptr_q) + k) % N] = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/rdma_qp_conn_sched.sv
// Connection scheduler in front of one RC QP: arbitrates connect/disconnect
// requests, walks the QP through RESET->INIT->RTR->RTS (or back to RESET),
// confirms each step on qp_state with a timeout, and recovers on failure.
module rdma_qp_conn_sched
  import rdma_qp_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int QPN_WIDTH   = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  rdma_qp_conn_sched_if.slave  req_if,
  output logic                 cfg_valid,
  output logic                 cmd_connect,
  output logic                 cmd_disconnect,
  output logic [QPN_WIDTH-1:0] remote_qpn,
  input  logic [2:0]           qp_state,
  output sched_state_e         dbg_state
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  sched_state_e         state_q, state_d;
  op_e                  op_q, op_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [QPN_WIDTH-1:0] qpn_q, qpn_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  rsp_code_e            code_q, code_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [1:0]           rsp_code_q, rsp_code_d;
  logic                 busy_q, busy_d;
  logic                 cfg_q, cfg_d, con_q, con_d, disc_q, disc_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_any;
  logic                 qp_err, tmo;

  rdma_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_if.req_valid),
    .en      (state_q == S_IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign qp_err = (qp_state == QP_ERROR);
  assign tmo    = (cnt_q == CW'(TIMEOUT_CYC - 1));

  // Next-state, latches and registered-output values.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    owner_d     = owner_q;
    qpn_d       = qpn_q;
    code_d      = code_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_code_d  = '0;
    // Counter is zero on entry to every wait state, then counts up and saturates.
    cnt_d = '0;
    if (is_wait_state(state_q)) begin
      cnt_d = (cnt_q == CW'(TIMEOUT_CYC)) ? cnt_q : cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          req_ready_d = gnt;
          op_d        = op_e'(req_if.req_op[gnt_idx]);
          qpn_d       = req_if.req_remote_qpn[gnt_idx*QPN_WIDTH +: QPN_WIDTH];
          owner_d     = gnt_idx;
          code_d      = RSP_OK;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (op_q == OP_CONNECT) begin
          if (qp_state == QP_RESET)    state_d = S_CFG;
          else if (qp_state == QP_RTS) state_d = S_RESP;
          else if (qp_err) begin
            state_d = S_ABORT;
            code_d  = RSP_QP_ERR;
          end else begin
            state_d = S_RESP;
            code_d  = RSP_BAD_STATE;
          end
        end else begin
          state_d = (qp_state == QP_RESET) ? S_RESP : S_DISC;
        end
      end
      S_CFG:   state_d = S_W_INIT;
      S_CON1:  state_d = S_W_RTR;
      S_CON2:  state_d = S_W_RTS;
      S_DISC:  state_d = S_W_RST;
      S_ABORT: state_d = S_W_ABORT;
      S_W_INIT, S_W_RTR, S_W_RTS: begin
        if ((state_q == S_W_INIT && qp_state == QP_INIT) ||
            (state_q == S_W_RTR  && qp_state == QP_RTR)  ||
            (state_q == S_W_RTS  && qp_state == QP_RTS)) begin
          state_d = (state_q == S_W_INIT) ? S_CON1 :
                    (state_q == S_W_RTR)  ? S_CON2 : S_RESP;
        end else if (qp_err || tmo) begin
          state_d = S_ABORT;
          code_d  = qp_err ? RSP_QP_ERR : RSP_TIMEOUT;
        end
      end
      // A failed disconnect has nothing left to undo, so it reports directly.
      S_W_RST: begin
        if (qp_state == QP_RESET) state_d = S_RESP;
        else if (qp_err || tmo) begin
          state_d = S_RESP;
          code_d  = qp_err ? RSP_QP_ERR : RSP_TIMEOUT;
        end
      end
      // Recovery outcome never overrides the original failure code.
      S_W_ABORT: begin
        if (qp_state == QP_RESET || qp_err || tmo) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid_d[owner_q] = 1'b1;
        rsp_code_d           = code_q;
        state_d              = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pulses coincide with their command state, so at most one is ever high.
    cfg_d  = (state_d == S_CFG);
    con_d  = (state_d == S_CON1) || (state_d == S_CON2);
    disc_d = (state_d == S_DISC) || (state_d == S_ABORT);
    busy_d = (state_d != S_IDLE) || (state_q == S_RESP);
  end

  // State and output registers; reset abandons any op silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_CONNECT;
      owner_q     <= '0;
      qpn_q       <= '0;
      cnt_q       <= '0;
      code_q      <= RSP_OK;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_code_q  <= '0;
      busy_q      <= 1'b0;
      cfg_q       <= 1'b0;
      con_q       <= 1'b0;
      disc_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      owner_q     <= owner_d;
      qpn_q       <= qpn_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      busy_q      <= busy_d;
      cfg_q       <= cfg_d;
      con_q       <= con_d;
      disc_q      <= disc_d;
    end
  end

  assign req_if.req_ready = req_ready_q;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_code  = rsp_code_q;
  assign req_if.busy      = busy_q;
  assign cfg_valid        = cfg_q;
  assign cmd_connect      = con_q;
  assign cmd_disconnect   = disc_q;
  assign remote_qpn       = qpn_q;
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_rdma_qp_conn_sched.sv
// Bench for rdma_qp_conn_sched: a QP model with 1-cycle state updates and
// injectable faults, a table-driven outcome model, and a scoreboard monitor.
module tb_rdma_qp_conn_sched;
  import rdma_qp_pkg::*;

  localparam int NR  = 4;
  localparam int QW  = 16;
  localparam int TMO = 64;
  localparam int EW  = 34; // {qpn16, owner2, code2, lat8, ncfg2, ncon2, ndisc2}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rdma_qp_conn_sched_if #(.NUM_REQ(NR), .QPN_WIDTH(QW)) sif ();

  logic          cfg_valid, cmd_connect, cmd_disconnect;
  logic [QW-1:0] remote_qpn;
  logic [2:0]    qp_state;
  sched_state_e  dbg_state;

  rdma_qp_conn_sched #(.NUM_REQ(NR), .QPN_WIDTH(QW), .TIMEOUT_CYC(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_if         (sif),
    .cfg_valid      (cfg_valid),
    .cmd_connect    (cmd_connect),
    .cmd_disconnect (cmd_disconnect),
    .remote_qpn     (remote_qpn),
    .qp_state       (qp_state),
    .dbg_state      (dbg_state)
  );

  // ---------------- QP model (0 normal, 1 stuck in INIT, 2 error on RTS) ----------------
  int         mode = 0;
  logic       force_en = 1'b0;
  logic [2:0] force_val = 3'b000;

  always @(posedge clk or posedge rst) begin
    if (rst) qp_state <= 3'b000;
    else if (force_en) qp_state <= force_val;
    else if (cfg_valid && qp_state == 3'b000) qp_state <= 3'b001;
    else if (cmd_connect) begin
      if (qp_state == 3'b001 && mode != 1) qp_state <= 3'b010;
      else if (qp_state == 3'b010) qp_state <= (mode == 2) ? 3'b111 : 3'b011;
    end else if (cmd_disconnect) qp_state <= 3'b000;
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            gnt_q[$];
  int            total = 0;
  int            bad = 0;
  int            mptr = 0;          // model RR pointer
  logic [2:0]    model_qp = 3'b000; // model QP state between ops

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outcome of one op given the QP state it meets at accept, from the
  // sequencing rules: code, cycles from req_ready to rsp_valid, pulse counts.
  function automatic void predict(input bit op, input logic [2:0] qp, input int md,
                                  output logic [1:0] code, output int lat,
                                  output int nc, output int nn, output int nd,
                                  output logic [2:0] nqp);
    nc = 0; nn = 0; nd = 0; nqp = qp;
    if (op == 1'b0) begin
      if (qp == 3'b000) begin
        if (md == 1)      begin code = 2'b01; lat = TMO + 7; nc = 1; nn = 1; nd = 1; nqp = 3'b000; end
        else if (md == 2) begin code = 2'b10; lat = 10;      nc = 1; nn = 2; nd = 1; nqp = 3'b000; end
        else              begin code = 2'b00; lat = 8;       nc = 1; nn = 2;         nqp = 3'b011; end
      end else if (qp == 3'b011) begin code = 2'b00; lat = 2; end
      else if (qp == 3'b111)     begin code = 2'b10; lat = 4; nd = 1; nqp = 3'b000; end
      else                       begin code = 2'b11; lat = 2; end
    end else begin
      if (qp == 3'b000) begin code = 2'b00; lat = 2; end
      else begin code = 2'b00; lat = 4; nd = 1; nqp = 3'b000; end
    end
  endfunction

  // Predict and queue the expected grant and response for one request.
  task automatic expect_op(input int idx, input bit op, input logic [QW-1:0] qpn, input int md);
    logic [1:0] code;
    int lat, nc, nn, nd;
    logic [2:0] nqp;
    predict(op, model_qp, md, code, lat, nc, nn, nd, nqp);
    model_qp = nqp;
    exp_q.push_back({qpn, 2'(idx), code, 8'(lat), 2'(nc), 2'(nn), 2'(nd)});
    gnt_q.push_back(idx);
    mptr = (idx + 1) % NR;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int idx, input bit op, input logic [QW-1:0] qpn);
    sif.req_valid[idx] = 1'b1;
    sif.req_op[idx] = op;
    sif.req_remote_qpn[idx*QW +: QW] = qpn;
  endtask

  task automatic wait_ready(input int idx);
    int n = 0;
    while (!sif.req_ready[idx] && n < 400) begin @(posedge clk); #1; n++; end
    if (n >= 400) chk("ready_timeout", 0, 1);
    sif.req_valid[idx] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sif.busy && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) chk("idle_timeout", 0, 1);
    mode = 0;
  endtask

  task automatic do_req(input int idx, input bit op, input logic [QW-1:0] qpn, input int md);
    expect_op(idx, op, qpn, md);
    mode = md;
    set_req(idx, op, qpn);
    wait_ready(idx);
    wait_idle();
  endtask

  task automatic force_qp(input logic [2:0] v);
    force_en = 1'b1; force_val = v;
    @(posedge clk); #1;
    force_en = 1'b0;
    model_qp = v;
  endtask

  // All requesters valid at once; grants must rotate from the model pointer.
  task automatic all_round();
    int start = mptr;
    for (int k = 0; k < NR; k++) begin
      int g = (start + k) % NR;
      logic [QW-1:0] q = QW'($urandom);
      bit op = 1'($urandom_range(0, 1));
      set_req(g, op, q);
      expect_op(g, op, q, 0);
    end
    for (int k = 0; k < NR; k++) wait_ready((start + k) % NR);
    wait_idle();
  endtask

  // ---------------- monitor ----------------
  initial begin
    int cyc = 0, acc_cyc = 0, pc = 0, pn = 0, pd = 0;
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (sif.rsp_valid != '0) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", sif.rsp_valid, 0);
          else begin
            e = exp_q.pop_front();
            chk("rsp_owner", sif.rsp_valid, 64'(4'b0001 << e[17:16]));
            chk("rsp_code", sif.rsp_code, e[15:14]);
            chk("rsp_latency", cyc - acc_cyc, e[13:6]);
            chk("n_cfg", pc, e[5:4]);
            chk("n_connect", pn, e[3:2]);
            chk("n_disconnect", pd, e[1:0]);
            chk("remote_qpn", remote_qpn, e[33:18]);
            chk("busy_in_rsp", sif.busy, 1);
          end
        end
        if (sif.req_ready != '0) begin
          chk("grant_onehot", $onehot(sif.req_ready), 1);
          if (gnt_q.size() == 0) chk("grant_unexpected", sif.req_ready, 0);
          else chk("grant_idx", sif.req_ready, 64'(4'b0001 << gnt_q.pop_front()));
          acc_cyc = cyc; pc = 0; pn = 0; pd = 0;
        end
        if (cfg_valid || cmd_connect || cmd_disconnect)
          chk("one_pulse", $onehot({cfg_valid, cmd_connect, cmd_disconnect}), 1);
        pc += int'(cfg_valid);
        pn += int'(cmd_connect);
        pd += int'(cmd_disconnect);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, sif.req_ready, 0);
    chk({tag, "_rsp_valid"}, sif.rsp_valid, 0);
    chk({tag, "_rsp_code"}, sif.rsp_code, 0);
    chk({tag, "_busy"}, sif.busy, 0);
    chk({tag, "_pulses"}, {cfg_valid, cmd_connect, cmd_disconnect}, 0);
    chk({tag, "_remote_qpn"}, remote_qpn, 0);
    chk({tag, "_state_idle"}, dbg_state, S_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sif.req_valid = '0;
    sif.req_op = '0;
    sif.req_remote_qpn = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // connect from RESET, then disconnect from RTS, then disconnect from RESET
    do_req(0, 1'b0, 16'h5678, 0);
    do_req(1, 1'b1, 16'h1111, 0);
    do_req(1, 1'b1, 16'h2222, 0);

    // simultaneous requests, two rounds
    all_round();
    all_round();

    // stuck in INIT -> timeout; error at RTS -> qp error; connect while RTR -> bad state
    force_qp(3'b000);
    do_req(2, 1'b0, 16'h0aaa, 1);
    do_req(3, 1'b0, 16'h0bbb, 2);
    force_qp(3'b010);
    do_req(0, 1'b0, 16'h0ccc, 0);
    force_qp(3'b111);
    do_req(1, 1'b0, 16'h0ddd, 0);

    // reset during W_RTR: op is dropped, outputs clear at once
    force_qp(3'b000);
    gnt_q.push_back(2);
    set_req(2, 1'b0, 16'h3333);
    wait_ready(2);
    begin
      int n = 0;
      while (dbg_state != S_W_RTR && n < 50) begin @(posedge clk); #1; n++; end
      chk("reach_w_rtr", dbg_state, S_W_RTR);
    end
    rst = 1'b1;
    #1;
    chk_all_zero("midop_reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mode = 0; mptr = 0; model_qp = 3'b000;
    gnt_q.delete();
    @(posedge clk); #1;
    do_req(2, 1'b0, 16'h4444, 0);

    // randomized ops against the model
    for (int it = 0; it < 24; it++) begin
      int idx = $urandom_range(0, NR - 1);
      bit op = 1'($urandom_range(0, 1));
      int md = 0;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 4))
          0: force_qp(3'b000);
          1: force_qp(3'b001);
          2: force_qp(3'b010);
          3: force_qp(3'b011);
          default: force_qp(3'b111);
        endcase
      end
      if (op == 1'b0 && model_qp == 3'b000) begin
        case ($urandom_range(0, 7))
          0: md = 1;
          1, 2: md = 2;
          default: md = 0;
        endcase
      end
      do_req(idx, op, QW'($urandom), md);
      if ($urandom_range(0, 2) == 0) all_round();
    end

    repeat (5) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("gnt_q_drained", gnt_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
